// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO.
// The FIFO pops on the edge a frame starts, so back-to-back bytes leave no idle gap.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [15:0]     baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic push, pop, baud_last;

  assign tx_ready   = (count_q < DEPTH_C);
  assign push       = tx_valid && tx_ready;
  assign baud_last  = (baud_q == BAUD_LAST);
  assign uart_tx    = tx_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = START;
          tx_d    = 1'b0;
          shift_d = mem_q[rd_ptr_q];
          bit_d   = '0;
          baud_d  = '0;
          pop     = 1'b1;
        end
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = '0;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit when more bytes are queued
          if (count_q != '0) begin
            state_d = START;
            tx_d    = 1'b0;
            shift_d = mem_q[rd_ptr_q];
            bit_d   = '0;
            pop     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised and directed bench for uart_tx_fifo, compared every cycle against
// a frame-position model of the serial line plus a byte queue.
module tb_uart_tx_fifo;

  localparam int CLKS  = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CLKS;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       uart_tx;
  logic       busy;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;

  // Model state: queued bytes, whether a frame is on the line, and how far into it
  logic [7:0] mQueue[$];
  logic       mActive = 1'b0;
  int         mPos = 0;
  logic [7:0] mByte = 8'h00;

  uart_tx_fifo #(.CLKS_PER_BIT(CLKS), .FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each edge: finish or advance the current frame, start a new one from the
  // queue head if the line is free, then accept the offered byte if room existed
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mQueue.delete();
      mActive = 1'b0;
      mPos    = 0;
    end else begin
      int   cnt;
      logic doPush;
      logic startNew;
      logic [7:0] pushed;
      cnt      = mQueue.size();
      doPush   = tx_valid && (cnt < DEPTH);
      pushed   = tx_data;
      startNew = 1'b0;
      if (mActive) begin
        if (mPos == FRAME - 1) begin
          if (cnt > 0) startNew = 1'b1;
          else mActive = 1'b0;
        end else begin
          mPos++;
        end
      end else if (cnt > 0) begin
        startNew = 1'b1;
      end
      if (startNew) begin
        mByte   = mQueue.pop_front();
        mActive = 1'b1;
        mPos    = 0;
      end
      if (doPush) mQueue.push_back(pushed);
    end
  end

  function automatic logic modelTx();
    int idx;
    if (!mActive) return 1'b1;
    idx = mPos / CLKS;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return mByte[idx-1];
  endfunction

  initial begin
    forever begin
      @(negedge clock);
      checkOutput("uart_tx", {31'd0, uart_tx}, {31'd0, modelTx()});
      checkOutput("busy", {31'd0, busy}, {31'd0, (mActive || mQueue.size() != 0)});
      checkOutput("fifo_count", {29'd0, fifo_count}, 32'(mQueue.size()));
      checkOutput("tx_ready", {31'd0, tx_ready}, {31'd0, (mQueue.size() < DEPTH)});
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clock);
    #1;
    tx_valid = 1'b1;
    tx_data  = b;
    @(posedge clock);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput("drain_to_idle", {31'd0, busy}, 32'd0);
  endtask

  // Push one byte into an idle block and check the middle of every bit cell
  task automatic sendAndCheckFrame(input logic [7:0] b);
    logic [9:0] frameBits;
    frameBits = {1'b1, b, 1'b0};
    applyStimulus(b);
    @(negedge clock);
    checkOutput("frame_queued_count", {29'd0, fifo_count}, 32'd1);
    checkOutput("frame_pre_line", {31'd0, uart_tx}, 32'd1);
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clock);
      if (j % CLKS == 2)
        checkOutput($sformatf("frame_%02h_bit%0d", b, j / CLKS), {31'd0, uart_tx}, {31'd0, frameBits[j / CLKS]});
    end
    checkOutput("frame_busy_last_cycle", {31'd0, busy}, 32'd1);
    @(negedge clock);
    checkOutput("frame_busy_fall", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] held [6];
    held = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("reset_ready", {31'd0, tx_ready}, 32'd1);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clock);

    $display("[TB] single frames");
    sendAndCheckFrame(8'hA5);
    sendAndCheckFrame(8'h00);
    sendAndCheckFrame(8'hFF);

    $display("[TB] back-to-back frames");
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    waitIdle(4 * FRAME);

    $display("[TB] fill while idle");
    repeat (2) @(negedge clock);
    #1;
    tx_valid = 1'b1;
    tx_data  = held[0];
    for (int i = 1; i < 6; i++) begin
      @(posedge clock);
      #1;
      if (i == 4) checkOutput("fill_ready_at_3", {31'd0, tx_ready}, 32'd1);
      if (i == 5) begin
        checkOutput("fill_count_full", {29'd0, fifo_count}, 32'd4);
        checkOutput("fill_ready_full", {31'd0, tx_ready}, 32'd0);
      end
      tx_data = held[i];
    end
    @(posedge clock);
    #1;
    checkOutput("fill_drop_count", {29'd0, fifo_count}, 32'd4);
    tx_valid = 1'b0;
    waitIdle(6 * FRAME);

    $display("[TB] push on pop edge");
    repeat (2) @(negedge clock);
    applyStimulus(8'h3A);
    applyStimulus(8'h3B);
    applyStimulus(8'h3C);
    repeat (38) @(posedge clock);
    #1;
    checkOutput("pushpop_before", {29'd0, fifo_count}, 32'd2);
    tx_valid = 1'b1;
    tx_data  = 8'h3D;
    @(posedge clock);
    #1;
    tx_valid = 1'b0;
    checkOutput("pushpop_after", {29'd0, fifo_count}, 32'd2);
    checkOutput("pushpop_restart", {31'd0, uart_tx}, 32'd0);
    waitIdle(5 * FRAME);

    $display("[TB] reset mid-frame");
    repeat (2) @(negedge clock);
    applyStimulus(8'hF0);
    applyStimulus(8'hC3);
    repeat (17) @(posedge clock);
    #1;
    checkOutput("midframe_bit3_low", {31'd0, uart_tx}, 32'd0);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_uart_tx", {31'd0, uart_tx}, 32'd1);
    checkOutput("abort_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_ready", {31'd0, tx_ready}, 32'd1);
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    checkOutput("post_reset_idle", {31'd0, busy}, 32'd0);
    sendAndCheckFrame(8'h55);

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      #1;
      tx_valid = ($urandom_range(0, 19) < 3);
      tx_data  = 8'($urandom);
    end
    @(negedge clock);
    #1 tx_valid = 1'b0;
    waitIdle(8 * FRAME);

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104: clock cycles per UART bit; legal range is 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: byte entries in the transmit FIFO; must be a power of 2 and at least 2.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port tx_data, input, 8 bits: byte offered for transmission.
REQ-006 SHALL have port tx_valid, input, 1 bit: tx_data is valid this cycle.
REQ-007 SHALL have port tx_ready, output, 1 bit: FIFO can accept a byte this cycle.
REQ-008 SHALL have port uart_tx, output, 1 bit: serial line, idle high, registered.
REQ-009 SHALL have port busy, output, 1 bit: FIFO non-empty or a frame in progress.
REQ-010 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1 bits: bytes currently held in the FIFO.

Function
REQ-011 SHALL drive tx_ready = (fifo_count < FIFO_DEPTH) combinationally from the registered count.
REQ-012 SHALL push tx_data into the FIFO on a rising edge where tx_valid && tx_ready; tx_valid while full is ignored and the byte dropped.
REQ-013 SHALL wrap read/write pointers modulo FIFO_DEPTH and preserve FIFO order.
REQ-014 SHALL pop the head byte on the edge where the FSM leaves IDLE.
REQ-015 SHALL leave fifo_count unchanged when push and pop occur on the same edge.
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-017 SHALL transition IDLE->START on an edge with fifo_count>0; on that edge uart_tx goes 0, the popped byte is latched into a shift register, and the bit counter and baud counter clear.
REQ-018 SHALL hold each bit on uart_tx for exactly CLKS_PER_BIT cycles using a baud counter that counts 0..CLKS_PER_BIT-1.
REQ-019 SHALL transition START->DATA at baud-counter terminal count, driving data bit 0 (LSB first).
REQ-020 SHALL emit 8 data bits in DATA, then move DATA->STOP after bit 7's period, driving uart_tx=1.
REQ-021 SHALL transition STOP->IDLE after one bit period if the FIFO is empty, otherwise STOP->START directly with no idle gap.
REQ-022 SHALL make a frame 10*CLKS_PER_BIT cycles long: 8N1 format.
REQ-023 SHALL give a push into an empty FIFO with the FSM idle at edge k a first start-bit edge at k+1.
REQ-024 SHALL not alter the frame in progress in response to tx_data/tx_valid changes.
REQ-025 SHALL drive busy = (state != IDLE) || (fifo_count != 0).

Reset
REQ-026 SHALL, while reset_n=0, asynchronously force uart_tx=1, state=IDLE, fifo_count=0, pointers=0, counters=0, and busy=0; tx_ready is then 1.
REQ-027 SHALL abort any frame in progress on reset mid-frame: uart_tx returns high immediately and queued bytes are discarded.
REQ-028 SHALL take no push or pop on the first rising edge after reset_n deasserts unless tx_valid is asserted; normal operation resumes on that edge.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-029 SHALL cover: push 0xA5 into idle block at edge k -> uart_tx = 0 for 4 cycles from k+1, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles; busy falls at the edge ending the stop bit (k+41).
REQ-030 SHALL cover: push 0x01,0x02,0x03 back-to-back -> three contiguous 40-cycle frames with no idle gap, bytes in order.
REQ-031 SHALL cover: hold tx_valid with an idle FSM until 5 bytes are offered -> the first is popped immediately, tx_ready stays 1 and the FIFO absorbs bytes 2-5 (count=4); a 6th offer while full -> tx_ready=0 and the byte is dropped.
REQ-032 SHALL cover: push on the same edge the FSM pops, with count=2 -> count remains 2.
REQ-033 SHALL cover: assert reset_n=0 during data bit 3 -> uart_tx=1 within the same cycle, count=0, busy=0; after release, a new push of 0x55 transmits correctly.
REQ-034 SHALL cover: 0x00 and 0xFF payloads -> correct frames; the stop bit is always 1.
